// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and widths.
package fetch_pkg;

   localparam int          INSTR_W          = 32;
   localparam int          PC_W_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, instruction output
// handshake and retire-time control. Signal suffixes are relative to the
// fetch unit. jr_i/rs_data_i only exist when FETCH_JR_EN is defined.
interface instr_fetch_unit_if #(
   parameter int PC_W = 32
);
   import fetch_pkg::*;

   // instruction memory side
   logic                imem_req_o;
   logic [PC_W-1:0]     imem_addr_o;
   logic                imem_ready_i;
   logic [INSTR_W-1:0]  imem_data_i;

   // downstream (decode) side
   logic [INSTR_W-1:0]  instr_o;
   logic                instr_valid_o;
   logic                instr_ready_i;
   logic [PC_W-1:0]     pc_plus4_o;
   logic                branch_taken_i;
   logic                jump_i;
`ifdef FETCH_JR_EN
   logic                jr_i;
   logic [PC_W-1:0]     rs_data_i;
`endif
   logic                misalign_o;

   modport master (
      output imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_plus4_o, misalign_o,
      input  imem_ready_i, imem_data_i, instr_ready_i, branch_taken_i, jump_i
`ifdef FETCH_JR_EN
      , input jr_i, rs_data_i
`endif
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_o, instr_valid_o, pc_plus4_o, misalign_o,
      output imem_ready_i, imem_data_i, instr_ready_i, branch_taken_i, jump_i
`ifdef FETCH_JR_EN
      , output jr_i, rs_data_i
`endif
   );

endinterface

// File: rtl/next_pc_gen.sv
// Combinational next-PC selection for a retiring instruction.
// Priority: jr > j/jal > taken branch > sequential.
module next_pc_gen
   import fetch_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic [PC_W-1:0]    pc_plus4_i,
   input  logic [INSTR_W-1:0] instr_i,
   input  logic               branch_taken_i,
   input  logic               jump_i,
   input  logic               jr_i,
   input  logic [PC_W-1:0]    rs_data_i,
   output logic [PC_W-1:0]    next_pc_o,
   output logic               misalign_o
);

   logic [PC_W-1:0] jump_target;
   logic [PC_W-1:0] branch_off;

   // The opcode field is decoded downstream, not here.
   logic unused_opcode;
   assign unused_opcode = &{1'b0, instr_i[31:26]};

   // Select redirect target; all arithmetic wraps modulo 2^PC_W.
   always_comb begin
      // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
      jump_target        = pc_plus4_i;
      jump_target[27:0]  = {instr_i[25:0], 2'b00};
      branch_off         = {{(PC_W-18){instr_i[15]}}, instr_i[15:0], 2'b00};
      next_pc_o          = pc_plus4_i;
      if (jr_i)
         next_pc_o = rs_data_i;
      else if (jump_i)
         next_pc_o = jump_target;
      else if (branch_taken_i)
         next_pc_o = pc_plus4_i + branch_off;
   end

   assign misalign_o = jr_i && (rs_data_i[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches from a wait-state memory,
// presents the instruction until retired, then redirects from the retire-time
// control bits. Define FETCH_JR_EN to enable jump-register redirect and the
// misalign halt; otherwise misalign_o stays 0 and HALT is never entered.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int              PC_W     = PC_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   instr_fetch_unit_if.master  bus
);

   state_e               state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic                 valid_q, valid_d;
   logic [PC_W-1:0]      pc_plus4_q, pc_plus4_d;
   logic                 misalign_q, misalign_d;

   logic                 jr_sel;
   logic [PC_W-1:0]      rs_sel;
   logic [PC_W-1:0]      next_pc;
   logic                 npc_misalign;

`ifdef FETCH_JR_EN
   assign jr_sel = bus.jr_i;
   assign rs_sel = bus.rs_data_i;
`else
   assign jr_sel = 1'b0;
   assign rs_sel = '0;
`endif

   next_pc_gen #(.PC_W(PC_W)) u_next_pc_gen (
      .pc_plus4_i     (pc_plus4_q),
      .instr_i        (instr_q),
      .branch_taken_i (bus.branch_taken_i),
      .jump_i         (bus.jump_i),
      .jr_i           (jr_sel),
      .rs_data_i      (rs_sel),
      .next_pc_o      (next_pc),
      .misalign_o     (npc_misalign)
   );

   // Next-state and datapath updates; control inputs matter only at retire.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      pc_plus4_d = pc_plus4_q;
      misalign_d = misalign_q;
      case (state_q)
         IDLE:  state_d = FETCH;
         FETCH: begin
            if (bus.imem_ready_i) begin
               instr_d    = bus.imem_data_i;
               valid_d    = 1'b1;
               pc_plus4_d = pc_q + PC_W'(4);
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (valid_q && bus.instr_ready_i) begin
               valid_d = 1'b0;
               if (npc_misalign) begin
                  misalign_d = 1'b1;
                  state_d    = HALT;
               end else begin
                  pc_d    = next_pc;
                  state_d = FETCH;
               end
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         valid_q    <= 1'b0;
         pc_plus4_q <= RESET_PC + PC_W'(4);
         misalign_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         pc_q       <= pc_d;
         instr_q    <= instr_d;
         valid_q    <= valid_d;
         pc_plus4_q <= pc_plus4_d;
         misalign_q <= misalign_d;
      end
   end

   // Request follows state so reset drops it without waiting for a clock.
   assign bus.imem_req_o    = (state_q == FETCH);
   assign bus.imem_addr_o   = pc_q;
   assign bus.instr_o       = instr_q;
   assign bus.instr_valid_o = valid_q;
   assign bus.pc_plus4_o    = pc_plus4_q;
   assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level model compared
// every cycle, directed literal checks, then randomized handshakes/control.
// jr tests are compiled in only with FETCH_JR_EN.
module tb_instr_fetch_unit;
   import fetch_pkg::*;

   logic clk   = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.PC_W(32)) bus  ();
   instr_fetch_unit_if #(.PC_W(32)) bus2 ();

   instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk_i (clk), .rst_i (rst_i), .bus (bus.master)
   );
   // Second instance only pins the jump target upper-nibble behaviour.
   instr_fetch_unit #(.PC_W(32), .RESET_PC(32'h4000_0000)) dut2 (
      .clk_i (clk), .rst_i (rst_i), .bus (bus2.master)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction memory contents: explicit words, else an address hash.
   logic [31:0] imem [logic [31:0]];
   function automatic logic [31:0] mem_read(input logic [31:0] a);
      if (imem.exists(a)) return imem[a];
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   // ---------------- behavioural model ----------------
   bit          m_started = 1'b0;  // one idle cycle after reset has elapsed
   bit          m_valid   = 1'b0;  // an unretired instruction is held
   bit          m_halt    = 1'b0;  // misaligned jr seen
   logic [31:0] m_pc      = 32'h0;
   logic [31:0] m_instr   = 32'h0;
   logic [31:0] m_pc4     = 32'h4;

   always @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         m_started = 1'b0; m_valid = 1'b0; m_halt = 1'b0;
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h4;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (m_halt) begin
         m_halt = 1'b1;
      end else if (!m_valid) begin
         if (bus.imem_ready_i) begin
            m_instr = bus.imem_data_i;
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
         end
      end else if (bus.instr_ready_i) begin
         int off;
         m_valid = 1'b0;
         off = int'($signed(m_instr[15:0]));
`ifdef FETCH_JR_EN
         if (bus.jr_i) begin
            if (bus.rs_data_i % 4 != 0) m_halt = 1'b1;
            else                        m_pc   = bus.rs_data_i;
         end else
`endif
         if (bus.jump_i)
            m_pc = (m_pc4 & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
         else if (bus.branch_taken_i)
            m_pc = m_pc4 + 32'(off * 4);
         else
            m_pc = m_pc4;
      end
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      check("imem_req",    32'(bus.imem_req_o),    32'(m_started && !m_valid && !m_halt));
      check("imem_addr",   bus.imem_addr_o,        m_pc);
      check("instr",       bus.instr_o,            m_instr);
      check("instr_valid", 32'(bus.instr_valid_o), 32'(m_valid));
      check("pc_plus4",    bus.pc_plus4_o,         m_pc4);
      check("misalign",    32'(bus.misalign_o),    32'(m_halt));
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.imem_data_i = mem_read(bus.imem_addr_o);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"},   32'(bus.imem_req_o),    32'h0);
      check({tag, "_addr"},  bus.imem_addr_o,        32'h0);
      check({tag, "_instr"}, bus.instr_o,            32'h0);
      check({tag, "_valid"}, 32'(bus.instr_valid_o), 32'h0);
      check({tag, "_pc4"},   bus.pc_plus4_o,         32'h4);
      check({tag, "_mis"},   32'(bus.misalign_o),    32'h0);
   endtask

   initial begin
      bus2.imem_ready_i   = 1'b1;
      bus2.imem_data_i    = 32'h0800_0100;   // j, target field 26'h100
      bus2.instr_ready_i  = 1'b1;
      bus2.branch_taken_i = 1'b1;
      bus2.jump_i         = 1'b1;
`ifdef FETCH_JR_EN
      bus2.jr_i           = 1'b0;
      bus2.rs_data_i      = 32'h0;
`endif
   end

   initial begin
      int n;
      imem[32'h10] = 32'h1000_FFFE;          // beq, offset -2 words
      imem[32'h14] = 32'h0800_0100;          // j 26'h100
      bus.imem_ready_i   = 1'b1;
      bus.imem_data_i    = mem_read(32'h0);
      bus.instr_ready_i  = 1'b1;
      bus.branch_taken_i = 1'b0;
      bus.jump_i         = 1'b0;
`ifdef FETCH_JR_EN
      bus.jr_i           = 1'b0;
      bus.rs_data_i      = 32'h0;
`endif
      #2 rst_i = 1'b0;
      #1 check_reset_values("rst");
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      bus.imem_data_i = mem_read(bus.imem_addr_o);

      // Straight-line fetch, zero wait states
      tick(1);
      check("first_req", 32'(bus.imem_req_o), 32'h1);
      check("first_addr", bus.imem_addr_o, 32'h0);
      tick(1);
      check("first_valid", 32'(bus.instr_valid_o), 32'h1);
      check("first_pc4", bus.pc_plus4_o, 32'h4);
      check("j_hi_pc4", bus2.pc_plus4_o, 32'h4000_0004);
      tick(1);
      check("addr_4", bus.imem_addr_o, 32'h4);
      check("j_hi_target", bus2.imem_addr_o, 32'h4000_0400);
      tick(2);
      check("addr_8", bus.imem_addr_o, 32'h8);

      // Three memory wait states at PC=8
      bus.imem_ready_i = 1'b0;
      check("wait_req0", 32'(bus.imem_req_o), 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("wait_req", 32'(bus.imem_req_o), 32'h1);
         check("wait_addr", bus.imem_addr_o, 32'h8);
      end
      bus.imem_ready_i = 1'b1;
      tick(1);
      check("wait_valid", 32'(bus.instr_valid_o), 32'h1);
      tick(1);
      check("addr_c", bus.imem_addr_o, 32'hC);

      // Backward taken branch at 0x10
      tick(2);
      check("addr_10", bus.imem_addr_o, 32'h10);
      tick(1);
      check("beq_instr", bus.instr_o, 32'h1000_FFFE);
      bus.branch_taken_i = 1'b1;
      tick(1);
      check("beq_back", bus.imem_addr_o, 32'hC);
      bus.branch_taken_i = 1'b0;
      imem[32'h10] = 32'h1000_0003;

      // Not-taken branch falls through
      tick(2);
      check("addr_10b", bus.imem_addr_o, 32'h10);
      tick(1);
      bus.branch_taken_i = 1'b0;
      tick(1);
      check("beq_fall", bus.imem_addr_o, 32'h14);

      // Jump beats a simultaneous taken branch
      tick(1);
      check("j_instr", bus.instr_o, 32'h0800_0100);
      bus.jump_i = 1'b1;
      bus.branch_taken_i = 1'b1;
      tick(1);
      check("j_target", bus.imem_addr_o, 32'h400);
      bus.jump_i = 1'b0;
      bus.branch_taken_i = 1'b0;

      // Randomized handshakes and control
      for (int i = 0; i < 3000; i++) begin
         tick(1);
         bus.imem_ready_i   = ($urandom_range(0, 9) < 7);
         bus.instr_ready_i  = ($urandom_range(0, 9) < 6);
         bus.branch_taken_i = $urandom_range(0, 1) == 1;
         bus.jump_i         = ($urandom_range(0, 3) == 0);
`ifdef FETCH_JR_EN
         bus.jr_i           = ($urandom_range(0, 7) == 0);
         bus.rs_data_i      = $urandom & 32'hFFFF_FFFC;
`endif
      end

      // Reset while a fetch is outstanding with ready pending
      bus.imem_ready_i = 1'b0; bus.instr_ready_i = 1'b1;
      bus.jump_i = 1'b0; bus.branch_taken_i = 1'b0;
`ifdef FETCH_JR_EN
      bus.jr_i = 1'b0;
`endif
      n = 0;
      while (!bus.imem_req_o && n < 20) begin tick(1); n++; end
      check("reach_fetch", 32'(bus.imem_req_o), 32'h1);
      bus.imem_ready_i = 1'b1;
      #2 rst_i = 1'b0;
      #1 check_reset_values("midrst");
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      bus.imem_data_i = mem_read(bus.imem_addr_o);
      tick(1);
      check("refetch_req", 32'(bus.imem_req_o), 32'h1);
      check("refetch_addr", bus.imem_addr_o, 32'h0);

`ifdef FETCH_JR_EN
      // Aligned jr redirect
      bus.instr_ready_i = 1'b0;
      n = 0;
      while (!bus.instr_valid_o && n < 20) begin tick(1); n++; end
      check("jr_held", 32'(bus.instr_valid_o), 32'h1);
      bus.jr_i = 1'b1; bus.rs_data_i = 32'h200; bus.instr_ready_i = 1'b1;
      tick(1);
      check("jr_target", bus.imem_addr_o, 32'h200);
      bus.jr_i = 1'b0; bus.instr_ready_i = 1'b0;

      // Misaligned jr halts fetch until reset
      n = 0;
      while (!bus.instr_valid_o && n < 20) begin tick(1); n++; end
      check("jr2_held", 32'(bus.instr_valid_o), 32'h1);
      bus.jr_i = 1'b1; bus.rs_data_i = 32'h202; bus.instr_ready_i = 1'b1;
      tick(1);
      check("mis_flag", 32'(bus.misalign_o), 32'h1);
      check("mis_req", 32'(bus.imem_req_o), 32'h0);
      check("mis_pc", bus.imem_addr_o, 32'h200);
      bus.jr_i = 1'b0;
      tick(5);
      check("mis_sticky", 32'(bus.misalign_o), 32'h1);
      check("mis_req_hold", 32'(bus.imem_req_o), 32'h0);
      rst_i = 1'b0;
      #1 check_reset_values("mis_clr");
      tick(1);
      rst_i = 1'b1;
`endif

      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage of the MIPS CPU, directly upstream of the main decoder and register file. Holds the PC, fetches each instruction from a wait-state instruction memory over a req/ready handshake, and presents it with a valid/ready handshake. Computes the next PC from branch/jump outcomes returned by downstream control when the instruction retires.

## Interface
- PC_W, 32, PC and address width
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- imem_req_o  out  1  fetch request to instruction memory
- imem_addr_o  out  PC_W  fetch address; equals current PC
- imem_ready_i  in  1  memory returns data this cycle
- imem_data_i  in  32  instruction word, valid with imem_ready_i
- instr_o  out  32  held instruction; opcode is bits [31:26]
- instr_valid_o  out  1  instr_o holds an unretired instruction
- instr_ready_i  in  1  downstream retires instr_o this cycle
- pc_plus4_o  out  PC_W  PC+4 of held instruction (for jal link)
- branch_taken_i  in  1  branch control AND ALU zero, for held instruction
- jump_i  in  1  j/jal, for held instruction
- jr_i  in  1  jump-register (only with FETCH_JR_EN)
- rs_data_i  in  PC_W  jr target (only with FETCH_JR_EN)
- misalign_o  out  1  sticky: jr target not word-aligned; fetch halted

## Operation
- States: IDLE, FETCH, HOLD, HALT.
- IDLE: entered on reset; one cycle, then FETCH.
- FETCH: imem_req_o=1, imem_addr_o=PC. On imem_ready_i: instr_o<=imem_data_i, instr_valid_o<=1, go HOLD. Otherwise stay; address stays stable.
- HOLD: imem_req_o=0; instr_o stable. On instr_valid_o && instr_ready_i (retire): PC<=next PC, instr_valid_o<=0, go FETCH.
- Next PC priority at retire: jr_i (rs_data_i) > jump_i ({pc_plus4[31:28], instr_o[25:0], 2'b00}) > branch_taken_i (pc_plus4 + (sign-extended instr_o[15:0] << 2)) > pc_plus4.
- Control inputs are sampled only at retire; ignored elsewhere.
- Arithmetic modulo 2^PC_W: PC 32'hFFFF_FFFC + 4 wraps to 0; branch offset wraps silently.
- jr with rs_data_i[1:0]!=0: at retire set misalign_o=1, go HALT; PC unchanged. HALT exits only through reset.
- Reset values: PC=RESET_PC, imem_req_o=0, instr_o=0, instr_valid_o=0, pc_plus4_o=RESET_PC+4, misalign_o=0, state=IDLE.
- Reset asserted mid-fetch drops imem_req_o immediately; any in-flight imem_ready_i is ignored.

## Timing
- Reset release to first imem_req_o: 1 cycle (IDLE).
- Zero-wait memory, instr_ready_i always high: FETCH, HOLD; one instruction per 2 cycles.
- Each memory wait state adds 1 cycle in FETCH; each cycle instr_ready_i is low adds 1 cycle in HOLD.
- pc_plus4_o is registered with instr_o and valid in the same cycle as instr_valid_o.
- New PC is visible on imem_addr_o in the cycle after retire.

## Configuration
- FETCH_JR_EN defined: jr_i and rs_data_i ports exist; jr redirect and misalign_o/HALT are active.
- Undefined: both ports absent, jr term removed from next-PC priority; misalign_o tied 0; HALT unreachable.

## Structure
- Shared package fetch_pkg: state enum (IDLE, FETCH, HOLD, HALT), default RESET_PC, INSTR_W=32.
- One combinational sub-module next_pc_gen: inputs pc_plus4, instr, control bits, rs_data; outputs next PC and misalign flag.

## Test plan
- Reset release, RESET_PC=0, ready always 1, instr_ready_i=1 -> imem_addr_o sequence 0,4,8,... with one new instruction every 2 cycles; pc_plus4_o=4 with first instruction.
- imem_ready_i held low 3 cycles at PC=8 -> imem_req_o and imem_addr_o=8 stable 4 cycles; instr_valid_o rises cycle after ready.
- Held beq at PC=0x10, imm=16'hFFFE, branch_taken_i=1 -> next fetch address 0x0C; same with imm=16'h0003 and taken=0 -> 0x14.
- j at pc_plus4=0x4000_0004, instr[25:0]=26'h0000100, branch_taken_i=1 simultaneously -> next address 0x4000_0400 (jump wins).
- FETCH_JR_EN: jr with rs_data_i=0x0000_0202 -> misalign_o=1, imem_req_o stays 0; only rst_i low clears it. With rs_data_i=0x200 -> next address 0x200.
- rst_i low during FETCH with pending ready -> outputs return to reset values asynchronously; refetch starts from RESET_PC.
